// File: rtl/pc_sequencer.sv
// Next-PC selection, program counter, return-address stack and loop counter; sel/next_pc are combinational,
// state commits one cycle after a pc_write strobe. No backpressure: every strobe outside BOOT is honoured.
module pc_sequencer #(
  parameter int                 WIDTH     = 16,
  parameter logic [WIDTH-1:0]   RESET_PC  = 16'h0000,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic             is_jump,
  input  logic             is_call,
  input  logic             is_ret,
  input  logic             is_branch,
  input  logic             branch_cond,
  input  logic             is_for,
  input  logic [5:0]       imm6,
  input  logic [8:0]       jump_off,
  input  logic             lc_load,
  input  logic [WIDTH-1:0] lc_value,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output logic [2:0]       sel,
  output logic             pc_increment,
  output logic [WIDTH-1:0] loop_cnt,
  output logic             ras_err
);

  localparam int SPW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW  = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] SEL_JUMP   = 3'b000;
  localparam logic [2:0] SEL_BRANCH = 3'b001;
  localparam logic [2:0] SEL_RET    = 3'b010;
  localparam logic [2:0] SEL_SEQ    = 3'b011;
  localparam logic [2:0] SEL_FOR    = 3'b100;

  localparam logic [WIDTH-1:0] LC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [SPW-1:0]   sp;
  logic [SPW-1:0]   sp_top;
  logic [CW-1:0]    ras_cnt;
  logic             ras_empty, ras_full;
  logic [WIDTH-1:0] ras_top;

  logic [WIDTH-1:0] imm_sext, pc_plus1, pc_rel, jump_tgt, npc;
  logic             for_taken, commit, do_push, do_pop;

  assign imm_sext  = {{(WIDTH-6){imm6[5]}}, imm6};
  assign pc_plus1  = pc + LC_ONE;
  assign pc_rel    = pc + imm_sext;
  assign jump_tgt  = {pc[WIDTH-1:9], jump_off};

  // sp names the next free slot, so the top of stack sits one below it.
  assign sp_top    = sp - 1'b1;
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CW'(RAS_DEPTH));
  assign ras_top   = ras_empty ? '0 : ras_mem[sp_top];

  assign for_taken = is_for & ~lc_load & (loop_cnt != '0) & (loop_cnt != LC_ONE);

  always_comb begin
    state_nxt = state;
    sel       = SEL_SEQ;
    npc       = pc_plus1;
    commit    = 1'b0;
    if (state == ST_BOOT) begin
      state_nxt = ST_RUN;
    end else begin
      commit = pc_write;
      if (is_ret) begin
        sel = SEL_RET;
        npc = ras_top;
      end else if (is_jump) begin
        sel = SEL_JUMP;
        npc = jump_tgt;
      end else if (is_branch && branch_cond) begin
        sel = SEL_BRANCH;
        npc = pc_rel;
      end else if (for_taken) begin
        sel = SEL_FOR;
        npc = pc_rel;
      end
    end
  end

  assign next_pc      = npc;
  assign pc_increment = (sel != SEL_SEQ);
  assign do_push      = commit & is_jump & is_call & ~is_ret;
  assign do_pop       = commit & is_ret;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      loop_cnt <= '0;
      sp       <= '0;
      ras_cnt  <= '0;
      ras_err  <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (commit) begin
        pc <= npc;

        if (lc_load)
          loop_cnt <= lc_value;
        else if (is_for && loop_cnt != '0)
          loop_cnt <= loop_cnt - LC_ONE;

        // A full stack keeps its count; the push lands on the oldest slot.
        if (do_push) begin
          ras_mem[sp] <= pc_plus1;
          sp          <= sp + 1'b1;
          if (ras_full) ras_err <= 1'b1;
          else          ras_cnt <= ras_cnt + 1'b1;
        end

        if (do_pop) begin
          if (ras_empty) begin
            ras_err <= 1'b1;
          end else begin
            sp      <= sp_top;
            ras_cnt <= ras_cnt - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected sel/pc pushed per step, popped after the commit edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, is_jump, is_call, is_ret, is_branch, branch_cond, is_for, lc_load;
  logic [5:0]  imm6;
  logic [8:0]  jump_off;
  logic [15:0] lc_value;
  logic [15:0] pc, next_pc, loop_cnt;
  logic [2:0]  sel;
  logic        pc_increment, ras_err;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .is_jump(is_jump), .is_call(is_call),
    .is_ret(is_ret), .is_branch(is_branch), .branch_cond(branch_cond), .is_for(is_for),
    .imm6(imm6), .jump_off(jump_off), .lc_load(lc_load), .lc_value(lc_value),
    .pc(pc), .next_pc(next_pc), .sel(sel), .pc_increment(pc_increment),
    .loop_cnt(loop_cnt), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        inc;
    logic        chk_npc;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  logic [15:0] ras_q[$];
  logic [15:0] cur;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    pc_write = 0; is_jump = 0; is_call = 0; is_ret = 0; is_branch = 0;
    branch_cond = 0; is_for = 0; lc_load = 0; imm6 = '0; jump_off = '0; lc_value = '0;
  endtask

  // Inputs are already driven (after a negedge). Push the expectation, sample the
  // combinational outputs, take the edge, then pop and compare.
  task automatic go(input string tag, input logic [2:0] esel, input logic einc,
                    input logic enpc, input logic [15:0] epc);
    exp_t e, got;
    string t;
    logic [2:0]  s_sel;
    logic        s_inc;
    logic [15:0] s_npc;
    e.sel = esel; e.inc = einc; e.chk_npc = enpc; e.pc = epc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    s_sel = sel; s_inc = pc_increment; s_npc = next_pc;
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    t   = tag_q.pop_front();
    chk({t, ".sel"}, {29'd0, s_sel}, {29'd0, got.sel});
    chk({t, ".inc"}, {31'd0, s_inc}, {31'd0, got.inc});
    if (got.chk_npc) chk({t, ".next_pc"}, {16'd0, s_npc}, {16'd0, got.pc});
    chk({t, ".pc"}, {16'd0, pc}, {16'd0, got.pc});
    cur = got.pc;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic step(input string tag, input logic [2:0] esel, input logic [15:0] epc);
    pc_write = 1;
    go(tag, esel, esel != 3'b011, 1'b1, epc);
  endtask

  task automatic jmp(input string tag, input logic [8:0] joff);
    logic [15:0] tgt;
    tgt = {cur[15:9], joff};
    is_jump = 1; jump_off = joff;
    step(tag, 3'b000, tgt);
  endtask

  task automatic call_to(input string tag, input logic [8:0] joff);
    logic [15:0] tgt, ra;
    tgt = {cur[15:9], joff};
    ra  = cur + 16'd1;
    ras_q.push_back(ra);
    if (ras_q.size() > 4) void'(ras_q.pop_front());
    is_jump = 1; is_call = 1; jump_off = joff;
    step(tag, 3'b000, tgt);
  endtask

  task automatic ret(input string tag);
    logic [15:0] tgt;
    tgt = (ras_q.size() > 0) ? ras_q.pop_back() : 16'h0000;
    is_ret = 1;
    step(tag, 3'b010, tgt);
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    cur   = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst.pc", {16'd0, pc}, 32'h0000);
    chk("rst.loop_cnt", {16'd0, loop_cnt}, 32'h0);
    chk("rst.ras_err", {31'd0, ras_err}, 32'h0);
    chk("rst.sel", {29'd0, sel}, 32'h3);
    chk("rst.inc", {31'd0, pc_increment}, 32'h0);
    reset = 0;

    // BOOT cycle: strobe ignored
    pc_write = 1;
    go("boot", 3'b011, 1'b0, 1'b0, 16'h0000);
    step("seq1", 3'b011, 16'h0001);
    step("seq2", 3'b011, 16'h0002);
    step("seq3", 3'b011, 16'h0003);

    jmp("j10a", 9'h010);
    is_branch = 1; branch_cond = 1; imm6 = 6'b111100;
    step("br_taken", 3'b001, 16'h000C);
    jmp("j10b", 9'h010);
    is_branch = 1; branch_cond = 0; imm6 = 6'b111100;
    step("br_not", 3'b011, 16'h0011);

    lc_load = 1; lc_value = 16'd3;
    step("lc_load3", 3'b011, 16'h0012);
    chk("lc_load3.cnt", {16'd0, loop_cnt}, 32'd3);
    for (int k = 0; k < 4; k++) begin
      jmp("j20", 9'h020);
      is_for = 1; imm6 = 6'b111100;
      if (k < 2) step("for_taken", 3'b100, 16'h001C);
      else       step("for_fall",  3'b011, 16'h0021);
      chk("for.cnt", {16'd0, loop_cnt}, (k < 3) ? 32'(2 - k) : 32'd0);
    end

    jmp("j20c", 9'h020);
    is_for = 1; imm6 = 6'b111100; lc_load = 1; lc_value = 16'd5;
    step("for_lcload", 3'b011, 16'h0021);
    chk("for_lcload.cnt", {16'd0, loop_cnt}, 32'd5);
    is_for = 1; imm6 = 6'b111100;
    step("for5", 3'b100, 16'h001D);
    chk("for5.cnt", {16'd0, loop_cnt}, 32'd4);
    is_for = 1; imm6 = 6'b111100;
    go("for_nowrite", 3'b100, 1'b1, 1'b0, 16'h001D);
    chk("for_nowrite.cnt", {16'd0, loop_cnt}, 32'd4);

    // walk up to 0x12xx with +31 branches, then land on 0x1234
    for (int n = 0; n < 400 && cur[15:9] != 7'h09; n++) begin
      is_branch = 1; branch_cond = 1; imm6 = 6'b011111;
      step("walk", 3'b001, cur + 16'd31);
    end
    jmp("j1234", 9'h034);
    chk("at1234", {16'd0, cur}, 32'h1234);

    call_to("call12ab", 9'h0AB);
    ret("ret1235");
    chk("ret1235.err", {31'd0, ras_err}, 32'h0);

    for (int i = 0; i < 5; i++) begin
      call_to("nest_call", 9'(9'h100 + i));
      chk("nest.err", {31'd0, ras_err}, (i == 4) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 4; i++) ret("nest_ret");

    call_to("call1250", 9'h050);
    is_jump = 1; is_call = 1; is_branch = 1; branch_cond = 1; jump_off = 9'h077;
    ret("prio_ret");
    ret("ret_empty");
    chk("ret_empty.err", {31'd0, ras_err}, 32'h1);

    is_branch = 1; branch_cond = 1; imm6 = 6'b100000;
    step("br_neg32", 3'b001, 16'hFFE0);
    jmp("jffff", 9'h1FF);
    step("wrap", 3'b011, 16'h0000);

    call_to("call5", 9'h005);
    lc_load = 1; lc_value = 16'd7;
    step("lc_load7", 3'b011, 16'h0006);
    chk("lc_load7.cnt", {16'd0, loop_cnt}, 32'd7);

    // reset wins over a simultaneous commit
    reset = 1; pc_write = 1; is_for = 1; imm6 = 6'b111100;
    @(posedge clk);
    #1;
    chk("midrst.pc", {16'd0, pc}, 32'h0000);
    chk("midrst.cnt", {16'd0, loop_cnt}, 32'h0);
    chk("midrst.err", {31'd0, ras_err}, 32'h0);
    @(negedge clk);
    clear_inputs();
    reset = 0;
    ras_q.delete();
    cur = 16'h0000;
    pc_write = 1; is_ret = 1;
    go("boot2", 3'b011, 1'b0, 1'b0, 16'h0000);
    ret("ret_after_rst");
    chk("ret_after_rst.err", {31'd0, ras_err}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
